// File: rtl/qlf_sync_fifo.sv
// Single-clock FIFO with registered read data, count-decoded status flags,
// programmable watermarks and sticky underrun/overrun indicators.
module qlf_sync_fifo #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK_i,
  input  logic                  RESET_i,
  input  logic                  FLUSH_i,
  input  logic                  WEN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  REN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  input  logic [ADDR_WIDTH-1:0] UPAF_i,
  input  logic [ADDR_WIDTH-1:0] UPAE_i,
  output logic                  EMPTY_o,
  output logic                  EPO_o,
  output logic                  EWM_o,
  output logic                  UNDERRUN_o,
  output logic                  FULL_o,
  output logic                  FMO_o,
  output logic                  FWM_o,
  output logic                  OVERRUN_o,
  output logic [ADDR_WIDTH:0]   COUNT_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_underrun;
  logic                  r_overrun;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_rd;
  logic [ADDR_WIDTH:0]   w_upaf;
  logic [ADDR_WIDTH:0]   w_upae;

  // Flags decode from the registered count only, so they lag the operation by one cycle.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_DEPTH);
  assign w_upaf  = {1'b0, UPAF_i};
  assign w_upae  = {1'b0, UPAE_i};

  assign w_wr = WEN_i && !w_full;
  assign w_rd = REN_i && !w_empty;

  assign EMPTY_o    = w_empty;
  assign FULL_o     = w_full;
  assign EPO_o      = (r_count == CNT_ONE);
  assign FMO_o      = (r_count == (CNT_DEPTH - CNT_ONE));
  assign EWM_o      = (r_count <= w_upae);
  assign FWM_o      = ((CNT_DEPTH - r_count) <= w_upaf);
  assign UNDERRUN_o = r_underrun;
  assign OVERRUN_o  = r_overrun;
  assign COUNT_o    = r_count;
  assign RDATA_o    = r_rdata;

  // Storage is not reset; reads only ever target locations already written.
  always_ff @(posedge CLK_i) begin
    if (w_wr && !FLUSH_i && !RESET_i) begin
      r_mem[r_wptr] <= WDATA_i;
    end
  end

  always_ff @(posedge CLK_i or posedge RESET_i) begin
    if (RESET_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rdata    <= '0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (FLUSH_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rdata    <= '0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rptr  <= r_rptr + PTR_ONE;
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (REN_i && w_empty) begin
        r_underrun <= 1'b1;
      end
      if (WEN_i && w_full) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule
